// File: rtl/mem_op_requester.sv
// Cache-side memory operation requester: accepts READ/RDEX/FLUSH requests,
// issues ring memory ops, collects fill words and handles retry/grant resends.
module mem_op_requester #(
    parameter logic [3:0] CORE_ID     = 4'd1,
    parameter logic [3:0] MSG_ADDRESS = 4'd2,
    parameter logic [3:0] MSG_GRANT   = 4'd6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic [1:0]   reqType,
    input  logic         reqUpgrade,
    input  logic [27:0]  reqAddr,
    input  logic [255:0] reqFlushData,
    input  logic         memOpQfull,
    output logic         wrMemOp,
    output logic [31:0]  memOpOut,
    output logic [3:0]   memOpDestOut,
    input  logic         writeDataQfull,
    output logic         wrWriteData,
    output logic [127:0] writeDataOut,
    input  logic [31:0]  RDreturn,
    input  logic [3:0]   RDdest,
    input  logic         resendValid,
    input  logic [39:0]  resendIn,
    output logic         fillValid,
    output logic [255:0] fillData,
    output logic         grantValid,
    output logic [7:0]   retryCount,
    output logic         protoErr
);
    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH_D0, S_FLUSH_D1, S_ISSUE, S_WAIT_FILL, S_WAIT_GRANT
    } state_t;

    localparam logic [1:0] T_FLUSH   = 2'b00;
    localparam logic [1:0] T_ILLEGAL = 2'b10;
    localparam logic [1:0] T_RDEX    = 2'b11;

    state_t         r_state, w_next;
    logic [1:0]     r_type;
    logic           r_upgrade;
    logic [27:0]    r_addr;
    logic [255:0]   r_flushData;
    logic           r_retry;
    logic [2:0]     r_cnt;
    logic [7:0]     r_retryCount;
    logic           r_protoErr;
    logic [255:0]   r_fillData;
    logic           r_fillValid;
    logic           r_grantValid;

    logic w_rdHit, w_rsMine, w_rsRetry, w_rsGrant;
    logic w_accept, w_issueFill, w_store, w_retry, w_lastWord, w_grant, w_err;

    assign w_rdHit   = (RDdest == CORE_ID);
    assign w_rsMine  = resendValid && (resendIn[39:36] == CORE_ID);
    assign w_rsRetry = w_rsMine && (resendIn[35:32] == MSG_ADDRESS);
    assign w_rsGrant = w_rsMine && (resendIn[35:32] == MSG_GRANT);

    assign memOpOut     = {r_retry, r_upgrade, r_type, r_addr & 28'hFFF_FFFE};
    assign memOpDestOut = CORE_ID;
    assign writeDataOut = (r_state == S_FLUSH_D1) ? r_flushData[255:128] : r_flushData[127:0];
    assign fillValid    = r_fillValid;
    assign fillData     = r_fillData;
    assign grantValid   = r_grantValid;
    assign retryCount   = r_retryCount;
    assign protoErr     = r_protoErr;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        reqReady    = 1'b0;
        wrMemOp     = 1'b0;
        wrWriteData = 1'b0;
        w_accept    = 1'b0;
        w_issueFill = 1'b0;
        w_store     = 1'b0;
        w_retry     = 1'b0;
        w_lastWord  = 1'b0;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                reqReady = reqValid;
                w_accept = reqValid;
                if (reqValid) begin
                    if (reqType == T_FLUSH)        w_next = S_FLUSH_D0;
                    else if (reqType != T_ILLEGAL) w_next = S_ISSUE;
                end
            end
            S_FLUSH_D0: if (!writeDataQfull) begin
                wrWriteData = 1'b1;
                w_next      = S_FLUSH_D1;
            end
            S_FLUSH_D1: if (!writeDataQfull) begin
                wrWriteData = 1'b1;
                w_next      = S_ISSUE;
            end
            S_ISSUE: if (!memOpQfull) begin
                wrMemOp = 1'b1;
                if (r_type == T_FLUSH)                   w_next = S_IDLE;
                else if (r_type == T_RDEX && r_upgrade)  w_next = S_WAIT_GRANT;
                else begin
                    w_next      = S_WAIT_FILL;
                    w_issueFill = 1'b1;
                end
            end
            S_WAIT_FILL: begin
                // A retry in the same cycle as a fill word discards the word.
                if (w_rsRetry) begin
                    w_retry = 1'b1;
                    w_next  = S_ISSUE;
                end else if (w_rdHit) begin
                    w_store = 1'b1;
                    if (r_cnt == 3'd7) begin
                        w_lastWord = 1'b1;
                        w_next     = S_IDLE;
                    end
                end
            end
            S_WAIT_GRANT: begin
                if (w_rsRetry) begin
                    w_retry = 1'b1;
                    w_next  = S_ISSUE;
                end else if (w_rsGrant) begin
                    w_grant = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (reset) begin
            reqReady    = 1'b0;
            wrMemOp     = 1'b0;
            wrWriteData = 1'b0;
        end
    end

    assign w_err = (w_rdHit && r_state != S_WAIT_FILL)
                || (w_rsGrant && r_state != S_WAIT_GRANT)
                || (w_accept && reqType == T_ILLEGAL);

    // Request payload only changes on acceptance, so it needs no reset.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_type      <= reqType;
            r_upgrade   <= reqUpgrade;
            r_addr      <= reqAddr;
            r_flushData <= reqFlushData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retry      <= 1'b0;
            r_cnt        <= '0;
            r_retryCount <= '0;
            r_protoErr   <= 1'b0;
            r_fillData   <= '0;
            r_fillValid  <= 1'b0;
            r_grantValid <= 1'b0;
        end else begin
            r_fillValid  <= w_lastWord;
            r_grantValid <= w_grant;
            if (w_err)       r_protoErr <= 1'b1;
            if (w_accept)    r_retry    <= 1'b0;
            if (w_issueFill) r_cnt      <= '0;
            if (w_store) begin
                r_fillData[{r_cnt, 5'b0} +: 32] <= RDreturn;
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_retry) begin
                r_retry <= 1'b1;
                r_cnt   <= '0;
                if (r_retryCount != 8'hFF) r_retryCount <= r_retryCount + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_op_requester.sv
// Directed, cycle-by-cycle vector bench for mem_op_requester.
module tb_mem_op_requester;
    logic         clock = 1'b0;
    logic         reset;
    logic         reqValid;
    logic         reqReady;
    logic [1:0]   reqType;
    logic         reqUpgrade;
    logic [27:0]  reqAddr;
    logic [255:0] reqFlushData;
    logic         memOpQfull;
    logic         wrMemOp;
    logic [31:0]  memOpOut;
    logic [3:0]   memOpDestOut;
    logic         writeDataQfull;
    logic         wrWriteData;
    logic [127:0] writeDataOut;
    logic [31:0]  RDreturn;
    logic [3:0]   RDdest;
    logic         resendValid;
    logic [39:0]  resendIn;
    logic         fillValid;
    logic [255:0] fillData;
    logic         grantValid;
    logic [7:0]   retryCount;
    logic         protoErr;

    localparam logic [127:0] FD_LO = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] FD_HI = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    mem_op_requester #(.CORE_ID(4'd1), .MSG_ADDRESS(4'd2), .MSG_GRANT(4'd6)) dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .reqType(reqType), .reqUpgrade(reqUpgrade), .reqAddr(reqAddr),
        .reqFlushData(reqFlushData), .memOpQfull(memOpQfull), .wrMemOp(wrMemOp),
        .memOpOut(memOpOut), .memOpDestOut(memOpDestOut), .writeDataQfull(writeDataQfull),
        .wrWriteData(wrWriteData), .writeDataOut(writeDataOut), .RDreturn(RDreturn),
        .RDdest(RDdest), .resendValid(resendValid), .resendIn(resendIn),
        .fillValid(fillValid), .fillData(fillData), .grantValid(grantValid),
        .retryCount(retryCount), .protoErr(protoErr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic rst; logic rv; logic [1:0] rt; logic up; logic mqf; logic wqf;
        logic [3:0] rdd; logic [31:0] rdw; logic rsv; logic [3:0] rsd; logic [3:0] rsty;
        logic e_rdy; logic e_wm; logic [31:0] e_mo; logic e_ww; logic [127:0] e_wd;
        logic e_fv; logic e_gv; logic [7:0] e_rc; logic e_pe;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned vec_no = 0;
    logic [7:0]   rc_exp = 8'd0;
    logic         pe_exp = 1'b0;
    logic [255:0] line_exp = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0h expected %0h", nm, vec_no, act, exp);
        end
    endtask

    function automatic vec_t nv();
        vec_t v;
        v.rst = 0; v.rv = 0; v.rt = 2'b01; v.up = 0; v.mqf = 0; v.wqf = 0;
        v.rdd = 0; v.rdw = 0; v.rsv = 0; v.rsd = 0; v.rsty = 0;
        v.e_rdy = 0; v.e_wm = 0; v.e_mo = 0; v.e_ww = 0; v.e_wd = 0;
        v.e_fv = 0; v.e_gv = 0; v.e_rc = rc_exp; v.e_pe = pe_exp;
        return v;
    endfunction

    function automatic vec_t mk(logic rv, logic [1:0] rt, logic up, logic mqf, logic wqf,
                                logic rsv, logic [3:0] rsd, logic [3:0] rsty,
                                logic e_rdy, logic e_wm, logic [31:0] e_mo,
                                logic e_ww, logic [127:0] e_wd, logic e_gv);
        vec_t v = nv();
        v.rv = rv; v.rt = rt; v.up = up; v.mqf = mqf; v.wqf = wqf;
        v.rsv = rsv; v.rsd = rsd; v.rsty = rsty;
        v.e_rdy = e_rdy; v.e_wm = e_wm; v.e_mo = e_mo; v.e_ww = e_ww; v.e_wd = e_wd;
        v.e_gv = e_gv;
        return v;
    endfunction

    task automatic step(input vec_t v);
        @(negedge clock);
        vec_no++;
        reset = v.rst; reqValid = v.rv; reqType = v.rt; reqUpgrade = v.up;
        memOpQfull = v.mqf; writeDataQfull = v.wqf; RDdest = v.rdd; RDreturn = v.rdw;
        resendValid = v.rsv; resendIn = {v.rsd, v.rsty, 32'h1234_5678};
        #1;
        chk("reqReady", reqReady, v.e_rdy);
        chk("wrMemOp", wrMemOp, v.e_wm);
        if (v.e_wm) chk("memOpOut", memOpOut, v.e_mo);
        chk("wrWriteData", wrWriteData, v.e_ww);
        if (v.e_ww) chk("writeDataOut", writeDataOut, v.e_wd);
        chk("exclusive_push", wrMemOp & wrWriteData, 0);
        chk("fillValid", fillValid, v.e_fv);
        chk("grantValid", grantValid, v.e_gv);
        chk("retryCount", retryCount, v.e_rc);
        chk("protoErr", protoErr, v.e_pe);
    endtask

    task automatic accept_read();
        vec_t v = nv();
        v.rv = 1; v.rt = 2'b01; v.e_rdy = 1;
        step(v);
    endtask

    task automatic issue(input logic [31:0] mo);
        vec_t v = nv();
        v.e_wm = 1; v.e_mo = mo;
        step(v);
    endtask

    task automatic rd_word(input logic [31:0] w);
        vec_t v = nv();
        v.rdd = 4'd1; v.rdw = w;
        step(v);
    endtask

    task automatic resend_retry();
        vec_t v = nv();
        v.rsv = 1; v.rsd = 4'd1; v.rsty = 4'd2;
        step(v);
        rc_exp = (rc_exp == 8'hFF) ? 8'hFF : rc_exp + 8'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        vec_t v;

        // Flush with write-data queue full for 3 cycles, then RDEX-upgrade with grants.
        tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0,             0, 0,     0);
        tbl[1]  = mk(0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 0,             0, 0,     0);
        tbl[2]  = mk(0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 0,             0, 0,     0);
        tbl[3]  = mk(0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 0,             0, 0,     0);
        tbl[4]  = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, FD_LO, 0);
        tbl[5]  = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, FD_HI, 0);
        tbl[6]  = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0040, 0, 0,     0);
        tbl[7]  = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0,     0);
        tbl[8]  = mk(1, 2'b11, 1, 0, 0, 0, 0, 0, 1, 0, 0,             0, 0,     0);
        tbl[9]  = mk(0, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0,             0, 0,     0);
        tbl[10] = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7000_0040, 0, 0,     0);
        tbl[11] = mk(0, 2'b01, 0, 0, 0, 1, 3, 6, 0, 0, 0,             0, 0,     0);
        tbl[12] = mk(0, 2'b01, 0, 0, 0, 1, 1, 5, 0, 0, 0,             0, 0,     0);
        tbl[13] = mk(0, 2'b01, 0, 0, 0, 1, 1, 6, 0, 0, 0,             0, 0,     0);
        tbl[14] = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0,     1);
        tbl[15] = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0,     0);

        reqAddr = 28'h000_0041;
        reqFlushData = {FD_HI, FD_LO};
        reset = 1; reqValid = 0; reqType = 2'b01; reqUpgrade = 0; memOpQfull = 0;
        writeDataQfull = 0; RDdest = 0; RDreturn = 0; resendValid = 0; resendIn = '0;
        repeat (3) @(posedge clock);

        step(nv());
        chk("reset_fillData", fillData, 256'd0);
        chk("memOpDestOut", memOpDestOut, 4'd1);

        for (int i = 0; i < 16; i++) step(tbl[i]);

        // READ, 8 words 1..8, a word for another core interleaved.
        accept_read();
        issue(32'h1000_0040);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                v = nv(); v.rdd = 4'd2; v.rdw = 32'hFFFF_FFFF; step(v);
            end
            rd_word(i + 1);
            line_exp[32*i +: 32] = i + 1;
        end
        v = nv(); v.e_fv = 1; step(v);
        chk("fill_word0", fillData[31:0], 32'd1);
        chk("fill_word7", fillData[255:224], 32'd8);
        chk("fill_line", fillData, line_exp);
        step(nv());

        // READ retried after 3 words; the colliding RD word is dropped.
        accept_read();
        issue(32'h1000_0040);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                v = nv(); v.rsv = 1; v.rsd = 4'd2; v.rsty = 4'd2; step(v);
            end
            rd_word(32'hA0 + i);
        end
        v = nv(); v.rsv = 1; v.rsd = 4'd1; v.rsty = 4'd2; v.rdd = 4'd1; v.rdw = 32'hDEAD_BEEF;
        step(v);
        rc_exp = 8'd1;
        issue(32'h9000_0040);
        for (int i = 0; i < 8; i++) begin
            rd_word(32'h100 + i);
            line_exp[32*i +: 32] = 32'h100 + i;
        end
        v = nv(); v.e_fv = 1; step(v);
        chk("retry_fill_line", fillData, line_exp);

        // RD for this core while idle is a sticky protocol error.
        rd_word(32'h55);
        pe_exp = 1'b1;
        step(nv());
        step(nv());

        // Retry count saturates at 255; the new request starts with retry clear.
        accept_read();
        issue(32'h1000_0040);
        for (int k = 0; k < 255; k++) begin
            resend_retry();
            issue(32'h9000_0040);
        end
        chk("retry_saturated", retryCount, 8'hFF);
        rd_word(32'h77);
        rd_word(32'h78);

        // Reset in WAIT_FILL with an RD word present.
        v = nv(); v.rst = 1; v.rv = 1; v.rdd = 4'd1; v.rdw = 32'h99;
        step(v);
        rc_exp = 8'd0; pe_exp = 1'b0;
        step(nv());
        chk("reset_fill_cleared", fillData, 256'd0);
        for (int i = 0; i < 10; i++) step(nv());

        // Illegal request type: accepted, dropped, error raised, still idle.
        v = nv(); v.rv = 1; v.rt = 2'b10; v.e_rdy = 1; step(v);
        pe_exp = 1'b1;
        step(nv());
        accept_read();
        issue(32'h1000_0040);
        v = nv(); v.rst = 1; step(v);
        pe_exp = 1'b0;
        step(nv());

        // Grant outside WAIT_GRANT is an error and does not pulse grantValid.
        v = nv(); v.rsv = 1; v.rsd = 4'd1; v.rsty = 4'd6; step(v);
        pe_exp = 1'b1;
        step(nv());
        step(nv());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
